// File: rtl/slave_access_ctrl.sv
// rtl/slave_access_ctrl.sv - one-at-a-time host register access sequencer over NUM_WORDS word slices.
// Broadcasts the latched request, then returns the single acking slice's data, or an error.
module slave_access_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            host_req,
  input  logic                            host_wr,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [DATA_WIDTH-1:0]           host_wdata,
  output logic                            host_busy,
  output logic                            host_ack,
  output logic                            host_err,
  output logic [DATA_WIDTH-1:0]           host_rdata,
  output logic                            slv_request,
  output logic [ADDR_WIDTH-1:0]           slv_address,
  output logic                            slv_wr,
  output logic [DATA_WIDTH-1:0]           slv_wdata,
  input  logic [NUM_WORDS-1:0]            slv_qack,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] slv_rdata,
  output logic                            ack_comb,
  output logic                            abort
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  w_in_wait;
  logic                  w_any;
  logic                  w_multi;
  logic [DATA_WIDTH-1:0] w_sel_rdata;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_any     = |slv_qack;
  // Clearing the lowest set bit leaves something only when two or more slices decoded the address.
  assign w_multi   = |(slv_qack & (slv_qack - NUM_WORDS'(1)));
  assign ack_comb  = w_in_wait & w_any;
  assign abort     = w_in_wait & ~w_any & (r_cnt == CNT_LAST);
  assign host_busy = (r_state != S_IDLE);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (slv_qack[i]) begin
        w_sel_rdata = w_sel_rdata | slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (host_req) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_any || abort) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      host_ack    <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= '0;
      slv_request <= 1'b0;
      slv_address <= '0;
      slv_wr      <= 1'b0;
      slv_wdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      slv_request <= (w_state_nxt == S_WAIT);
      host_ack    <= w_in_wait && (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (host_req) begin
            slv_address <= host_addr;
            slv_wr      <= host_wr;
            slv_wdata   <= host_wdata;
            r_cnt       <= '0;
          end
        end
        S_WAIT: begin
          // An ack in the last counted cycle wins over the timeout.
          if (w_any) begin
            host_err   <= w_multi;
            host_rdata <= (slv_wr || w_multi) ? '0 : w_sel_rdata;
          end else if (abort) begin
            host_err   <= 1'b1;
            host_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_access_ctrl.sv
// tb/tb_slave_access_ctrl.sv - directed bench for slave_access_ctrl with TIMEOUT=8 and TIMEOUT=4 instances.
module tb_slave_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [NW-1:0] slv_qack;
  logic [NW*DW-1:0] slv_rdata;

  logic          d8_host_busy, d8_host_ack, d8_host_err, d8_slv_request, d8_slv_wr, d8_ack_comb, d8_abort;
  logic [DW-1:0] d8_host_rdata, d8_slv_wdata;
  logic [AW-1:0] d8_slv_address;
  logic          d4_host_busy, d4_host_ack, d4_host_err, d4_slv_request, d4_slv_wr, d4_ack_comb, d4_abort;
  logic [DW-1:0] d4_host_rdata, d4_slv_wdata;
  logic [AW-1:0] d4_slv_address;

  int n_cmp = 0;
  int n_bad = 0;

  slave_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .TIMEOUT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_busy(d8_host_busy), .host_ack(d8_host_ack), .host_err(d8_host_err),
    .host_rdata(d8_host_rdata), .slv_request(d8_slv_request), .slv_address(d8_slv_address),
    .slv_wr(d8_slv_wr), .slv_wdata(d8_slv_wdata), .slv_qack(slv_qack), .slv_rdata(slv_rdata),
    .ack_comb(d8_ack_comb), .abort(d8_abort)
  );

  slave_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_busy(d4_host_busy), .host_ack(d4_host_ack), .host_err(d4_host_err),
    .host_rdata(d4_host_rdata), .slv_request(d4_slv_request), .slv_address(d4_slv_address),
    .slv_wr(d4_slv_wr), .slv_wdata(d4_slv_wdata), .slv_qack(slv_qack), .slv_rdata(slv_rdata),
    .ack_comb(d4_ack_comb), .abort(d4_abort)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_req = 1'b1; host_wr = 1'b1; host_addr = 16'hFFFF; host_wdata = 32'hFFFF_FFFF;
    slv_qack = '0;
    for (int i = 0; i < NW; i++) slv_rdata[i*DW +: DW] = 32'hA5A5_0000 | i;
    cyc(); cyc(); smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", d8_host_busy); end
    n_cmp++; if (d8_host_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got=%b exp=0", d8_host_ack); end
    n_cmp++; if (d8_host_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", d8_host_err); end
    n_cmp++; if (d8_host_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", d8_host_rdata); end
    n_cmp++; if (d8_slv_request !== 1'b0) begin n_bad++; $display("FAIL rst_slv_req got=%b exp=0", d8_slv_request); end
    n_cmp++; if (d8_slv_address !== 16'h0) begin n_bad++; $display("FAIL rst_slv_addr got=%h exp=0", d8_slv_address); end
    n_cmp++; if (d8_slv_wr !== 1'b0) begin n_bad++; $display("FAIL rst_slv_wr got=%b exp=0", d8_slv_wr); end
    n_cmp++; if (d8_slv_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_slv_wdata got=%h exp=0", d8_slv_wdata); end
    n_cmp++; if (d8_ack_comb !== 1'b0) begin n_bad++; $display("FAIL rst_ack_comb got=%b exp=0", d8_ack_comb); end
    n_cmp++; if (d8_abort !== 1'b0) begin n_bad++; $display("FAIL rst_abort got=%b exp=0", d8_abort); end
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    cyc(); rst_n = 1'b1;
    cyc(); smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy got=%b exp=0", d8_host_busy); end
  endtask

  task automatic test_read_immediate();
    cyc(); host_req = 1'b1; host_wr = 1'b0; host_addr = 16'd3; host_wdata = 32'h0;
    smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL rd_c0_busy got=%b exp=0", d8_host_busy); end
    cyc(); host_req = 1'b0; smp();
    n_cmp++; if (d8_host_busy !== 1'b1) begin n_bad++; $display("FAIL rd_c1_busy got=%b exp=1", d8_host_busy); end
    n_cmp++; if (d8_slv_request !== 1'b1) begin n_bad++; $display("FAIL rd_c1_slv_req got=%b exp=1", d8_slv_request); end
    n_cmp++; if (d8_slv_address !== 16'd3) begin n_bad++; $display("FAIL rd_c1_slv_addr got=%h exp=3", d8_slv_address); end
    n_cmp++; if (d8_ack_comb !== 1'b0) begin n_bad++; $display("FAIL rd_c1_ack_comb got=%b exp=0", d8_ack_comb); end
    cyc(); slv_qack = 8'h08; smp();
    n_cmp++; if (d8_ack_comb !== 1'b1) begin n_bad++; $display("FAIL rd_c2_ack_comb got=%b exp=1", d8_ack_comb); end
    n_cmp++; if (d8_abort !== 1'b0) begin n_bad++; $display("FAIL rd_c2_abort got=%b exp=0", d8_abort); end
    n_cmp++; if (d8_host_ack !== 1'b0) begin n_bad++; $display("FAIL rd_c2_ack got=%b exp=0", d8_host_ack); end
    cyc(); slv_qack = '0; smp();
    n_cmp++; if (d8_host_ack !== 1'b1) begin n_bad++; $display("FAIL rd_c3_ack got=%b exp=1", d8_host_ack); end
    n_cmp++; if (d8_host_err !== 1'b0) begin n_bad++; $display("FAIL rd_c3_err got=%b exp=0", d8_host_err); end
    n_cmp++; if (d8_host_rdata !== 32'hA5A5_0003) begin n_bad++; $display("FAIL rd_c3_rdata got=%h exp=a5a50003", d8_host_rdata); end
    n_cmp++; if (d8_ack_comb !== 1'b0) begin n_bad++; $display("FAIL rd_c3_ack_comb got=%b exp=0", d8_ack_comb); end
    n_cmp++; if (d8_slv_request !== 1'b0) begin n_bad++; $display("FAIL rd_c3_slv_req got=%b exp=0", d8_slv_request); end
    cyc(); smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL rd_c4_busy got=%b exp=0", d8_host_busy); end
    n_cmp++; if (d8_host_ack !== 1'b0) begin n_bad++; $display("FAIL rd_c4_ack got=%b exp=0", d8_host_ack); end
  endtask

  task automatic test_write_late();
    cyc(); host_req = 1'b1; host_wr = 1'b1; host_addr = 16'd5; host_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 9; c++) begin
      cyc(); host_req = 1'b0; slv_qack = (c == 7) ? 8'h20 : 8'h00; smp();
      n_cmp++; if (d8_ack_comb !== (c == 7)) begin n_bad++; $display("FAIL wr_c%0d_ack_comb got=%b exp=%b", c, d8_ack_comb, (c == 7)); end
      n_cmp++; if (d8_abort !== 1'b0) begin n_bad++; $display("FAIL wr_c%0d_abort got=%b exp=0", c, d8_abort); end
      n_cmp++; if (d8_host_ack !== (c == 8)) begin n_bad++; $display("FAIL wr_c%0d_ack got=%b exp=%b", c, d8_host_ack, (c == 8)); end
      if (c <= 7) begin
        n_cmp++; if (d8_slv_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_c%0d_wdata got=%h exp=deadbeef", c, d8_slv_wdata); end
        n_cmp++; if (d8_slv_request !== 1'b1) begin n_bad++; $display("FAIL wr_c%0d_slv_req got=%b exp=1", c, d8_slv_request); end
        n_cmp++; if (d8_slv_wr !== 1'b1) begin n_bad++; $display("FAIL wr_c%0d_slv_wr got=%b exp=1", c, d8_slv_wr); end
      end
      if (c == 8) begin
        n_cmp++; if (d8_host_err !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", d8_host_err); end
        n_cmp++; if (d8_host_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got=%h exp=0", d8_host_rdata); end
      end
    end
    host_wr = 1'b0;
  endtask

  task automatic test_timeout();
    cyc(); host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0100;
    for (int c = 1; c <= 10; c++) begin
      cyc(); host_req = 1'b0; slv_qack = '0; smp();
      n_cmp++; if (d4_abort !== (c == 4)) begin n_bad++; $display("FAIL to4_c%0d_abort got=%b exp=%b", c, d4_abort, (c == 4)); end
      n_cmp++; if (d4_host_ack !== (c == 5)) begin n_bad++; $display("FAIL to4_c%0d_ack got=%b exp=%b", c, d4_host_ack, (c == 5)); end
      n_cmp++; if (d8_abort !== (c == 8)) begin n_bad++; $display("FAIL to8_c%0d_abort got=%b exp=%b", c, d8_abort, (c == 8)); end
      n_cmp++; if (d8_host_ack !== (c == 9)) begin n_bad++; $display("FAIL to8_c%0d_ack got=%b exp=%b", c, d8_host_ack, (c == 9)); end
      if (c == 5) begin
        n_cmp++; if (d4_host_err !== 1'b1) begin n_bad++; $display("FAIL to4_err got=%b exp=1", d4_host_err); end
        n_cmp++; if (d4_host_rdata !== 32'h0) begin n_bad++; $display("FAIL to4_rdata got=%h exp=0", d4_host_rdata); end
      end
      if (c == 9) begin
        n_cmp++; if (d8_host_err !== 1'b1) begin n_bad++; $display("FAIL to8_err got=%b exp=1", d8_host_err); end
        n_cmp++; if (d8_host_rdata !== 32'h0) begin n_bad++; $display("FAIL to8_rdata got=%h exp=0", d8_host_rdata); end
      end
    end
  endtask

  task automatic test_multi_ack();
    cyc(); host_req = 1'b1; host_wr = 1'b0; host_addr = 16'd6;
    cyc(); host_req = 1'b0;
    cyc(); slv_qack = 8'h06; smp();
    n_cmp++; if (d8_ack_comb !== 1'b1) begin n_bad++; $display("FAIL multi_ack_comb got=%b exp=1", d8_ack_comb); end
    n_cmp++; if (d8_abort !== 1'b0) begin n_bad++; $display("FAIL multi_abort got=%b exp=0", d8_abort); end
    cyc(); slv_qack = '0; smp();
    n_cmp++; if (d8_host_ack !== 1'b1) begin n_bad++; $display("FAIL multi_ack got=%b exp=1", d8_host_ack); end
    n_cmp++; if (d8_host_err !== 1'b1) begin n_bad++; $display("FAIL multi_err got=%b exp=1", d8_host_err); end
    n_cmp++; if (d8_host_rdata !== 32'h0) begin n_bad++; $display("FAIL multi_rdata got=%h exp=0", d8_host_rdata); end
    cyc();
  endtask

  task automatic test_ack_at_timeout();
    cyc(); host_req = 1'b1; host_wr = 1'b0; host_addr = 16'd5;
    for (int c = 1; c <= 3; c++) begin
      cyc(); host_req = 1'b0; smp();
      n_cmp++; if (d4_abort !== 1'b0) begin n_bad++; $display("FAIL edge_c%0d_abort got=%b exp=0", c, d4_abort); end
    end
    cyc(); slv_qack = 8'h20; smp();
    n_cmp++; if (d4_ack_comb !== 1'b1) begin n_bad++; $display("FAIL edge_ack_comb got=%b exp=1", d4_ack_comb); end
    n_cmp++; if (d4_abort !== 1'b0) begin n_bad++; $display("FAIL edge_abort got=%b exp=0", d4_abort); end
    cyc(); slv_qack = '0; smp();
    n_cmp++; if (d4_host_ack !== 1'b1) begin n_bad++; $display("FAIL edge_ack got=%b exp=1", d4_host_ack); end
    n_cmp++; if (d4_host_err !== 1'b0) begin n_bad++; $display("FAIL edge_err got=%b exp=0", d4_host_err); end
    n_cmp++; if (d4_host_rdata !== 32'hA5A5_0005) begin n_bad++; $display("FAIL edge_rdata got=%h exp=a5a50005", d4_host_rdata); end
    cyc(); smp();
    n_cmp++; if (d4_host_busy !== 1'b0) begin n_bad++; $display("FAIL edge_idle_busy got=%b exp=0", d4_host_busy); end
  endtask

  task automatic test_reset_mid_access();
    cyc(); host_req = 1'b1; host_wr = 1'b0; host_addr = 16'd2;
    cyc(); host_req = 1'b0;
    cyc(); rst_n = 1'b0; #1;
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", d8_host_busy); end
    n_cmp++; if (d8_slv_request !== 1'b0) begin n_bad++; $display("FAIL mid_slv_req got=%b exp=0", d8_slv_request); end
    n_cmp++; if (d8_slv_address !== 16'h0) begin n_bad++; $display("FAIL mid_slv_addr got=%h exp=0", d8_slv_address); end
    n_cmp++; if (d4_host_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy4 got=%b exp=0", d4_host_busy); end
    cyc(); rst_n = 1'b1; smp();
    n_cmp++; if (d8_host_ack !== 1'b0) begin n_bad++; $display("FAIL mid_noack got=%b exp=0", d8_host_ack); end
    cyc(); smp();
    n_cmp++; if (d8_host_ack !== 1'b0) begin n_bad++; $display("FAIL mid_noack2 got=%b exp=0", d8_host_ack); end
    cyc(); host_req = 1'b1; host_addr = 16'd1;
    cyc(); host_req = 1'b0; smp();
    n_cmp++; if (d8_slv_address !== 16'd1) begin n_bad++; $display("FAIL busy_addr1 got=%h exp=1", d8_slv_address); end
    cyc(); host_req = 1'b1; host_addr = 16'd2; slv_qack = 8'h02; smp();
    n_cmp++; if (d8_ack_comb !== 1'b1) begin n_bad++; $display("FAIL busy_ack_comb got=%b exp=1", d8_ack_comb); end
    n_cmp++; if (d8_slv_address !== 16'd1) begin n_bad++; $display("FAIL busy_addr2 got=%h exp=1", d8_slv_address); end
    cyc(); host_req = 1'b0; slv_qack = '0; smp();
    n_cmp++; if (d8_host_ack !== 1'b1) begin n_bad++; $display("FAIL busy_ack got=%b exp=1", d8_host_ack); end
    n_cmp++; if (d8_host_err !== 1'b0) begin n_bad++; $display("FAIL busy_err got=%b exp=0", d8_host_err); end
    n_cmp++; if (d8_host_rdata !== 32'hA5A5_0001) begin n_bad++; $display("FAIL busy_rdata got=%h exp=a5a50001", d8_host_rdata); end
    cyc(); smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL busy_idle got=%b exp=0", d8_host_busy); end
    cyc(); smp();
    n_cmp++; if (d8_host_busy !== 1'b0) begin n_bad++; $display("FAIL busy_not_queued got=%b exp=0", d8_host_busy); end
    n_cmp++; if (d8_slv_request !== 1'b0) begin n_bad++; $display("FAIL busy_not_queued_req got=%b exp=0", d8_slv_request); end
  endtask

  initial begin
    test_reset();
    test_read_immediate();
    test_write_late();
    test_timeout();
    test_multi_ack();
    test_ack_at_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
